// File: rtl/div_pkg.sv
// Shared definitions for the divider front-end: default width, response
// error codes and the sequencer state encoding.
package div_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_OVF     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Request, response and divider-side signals of the sequencer. The slave
// modport is the sequencer's view; master is the surrounding ALU/bench.
interface div_sequencer_if #(
    parameter int WIDTH = div_pkg::WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_quot;
    logic [WIDTH-1:0] rsp_rem;
    logic [1:0]       rsp_err;

    logic [WIDTH-1:0] div_dividen;
    logic [WIDTH-1:0] div_divisor;
    logic             div_start;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             div_done;
    logic             div_overflow;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        input  div_quotient, div_remainder, div_done, div_overflow,
        output req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_err,
        output div_dividen, div_divisor, div_start
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        output div_quotient, div_remainder, div_done, div_overflow,
        input  req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_err,
        input  div_dividen, div_divisor, div_start
    );

endinterface

// File: rtl/div_watchdog.sv
// WAIT-state watchdog: saturating cycle counter plus an 'armed' flag that
// only sets once div_done has been seen low, masking a stale done level.
module div_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_a,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_done,
    output logic o_expired,
    output logic o_done_q
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_armed;

    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (i_en) begin
            if (r_cnt != LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (!i_done) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_expired = (r_cnt == LAST);
    assign o_done_q  = r_armed;

endmodule

// File: rtl/div_sequencer.sv
// Front-end for the sequential divider: screens divide-by-zero, launches the
// divider, waits for done under a watchdog and returns a registered response.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH   = div_pkg::WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset_a,
    div_sequencer_if.slave bus
);
    // state  | meaning
    // IDLE   | req_ready high, waiting for a request
    // LAUNCH | one-cycle div_start pulse, watchdog cleared
    // WAIT   | waiting for an armed div_done or watchdog expiry
    // RESP   | rsp_valid high, response held until rsp_ready
    state_t           r_state;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_quot;
    logic [WIDTH-1:0] r_rsp_rem;
    logic [1:0]       r_rsp_err;
    logic [WIDTH-1:0] r_dividen;
    logic [WIDTH-1:0] r_divisor;
    logic             r_div_start;

    logic w_wd_clr;
    logic w_wd_en;
    logic w_expired;
    logic w_done_q;

    assign w_wd_clr = (r_state == ST_LAUNCH);
    assign w_wd_en  = (r_state == ST_WAIT);

    div_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .reset_a   (reset_a),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .i_done    (bus.div_done),
        .o_expired (w_expired),
        .o_done_q  (w_done_q)
    );

    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_quot  <= '0;
            r_rsp_rem   <= '0;
            r_rsp_err   <= ERR_OK;
            r_dividen   <= '0;
            r_divisor   <= '0;
            r_div_start <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (r_req_ready && bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_dividen   <= bus.req_a;
                        r_divisor   <= bus.req_b;
                        if (bus.req_b == '0) begin
                            r_rsp_quot  <= '1;
                            r_rsp_rem   <= bus.req_a;
                            r_rsp_err   <= ERR_DIV0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_div_start <= 1'b1;
                            r_state     <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_div_start <= 1'b0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An armed done takes priority over a simultaneous expiry.
                    if (w_done_q && bus.div_done) begin
                        r_rsp_quot  <= bus.div_quotient;
                        r_rsp_rem   <= bus.div_remainder;
                        r_rsp_err   <= bus.div_overflow ? ERR_OVF : ERR_OK;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_expired) begin
                        r_rsp_quot  <= '0;
                        r_rsp_rem   <= '0;
                        r_rsp_err   <= ERR_TIMEOUT;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_quot    = r_rsp_quot;
    assign bus.rsp_rem     = r_rsp_rem;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.div_dividen = r_dividen;
    assign bus.div_divisor = r_divisor;
    assign bus.div_start   = r_div_start;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: random requests against a divider model, with a
// scoreboard of expected responses checked by an independent monitor.
module tb_div_sequencer;
    import div_pkg::*;

    localparam int W  = 16;
    localparam int TO = 64;

    logic clk     = 1'b0;
    logic reset_a = 1'b1;
    always #5 clk = ~clk;

    div_sequencer_if #(.WIDTH(W)) bus ();

    div_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [1:0]   err;
        int           lat;
        int           starts;
        int           hs;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           ovf;
        bit           never;
        int           stale;
        int           lat;
    } scen_t;

    exp_t  exp_q[$];
    scen_t scen_q[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int start_cnt = 0;
    int stall_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_div_start"}, 64'(bus.div_start), 64'd0);
        check({tag, "_rsp_data"}, {bus.rsp_quot, bus.rsp_rem, bus.rsp_err}, 64'd0);
        check({tag, "_operands"}, {bus.div_dividen, bus.div_divisor}, 64'd0);
    endtask

    // Issue one request; the divider's behaviour for it is queued alongside.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit ovf,
                        input bit never, input int stale, input int lat);
        scen_t s;
        exp_t  e;
        int    guard;
        s.a = a; s.b = b; s.ovf = ovf; s.never = never; s.stale = stale; s.lat = lat;
        s.q = ovf ? W'($urandom) : ((b != 0) ? a / b : '0);
        s.r = ovf ? W'($urandom) : ((b != 0) ? a % b : '0);
        if (b != 0) scen_q.push_back(s);
        @(negedge clk);
        bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            n_tests++; n_fail++;
            $display("FAIL req_accept: req_ready still 0 after %0d cycles, expected 1", guard);
            bus.req_valid = 1'b0;
            return;
        end
        if (b == 0) begin
            e.q = '1; e.r = a; e.err = ERR_DIV0; e.lat = 0; e.starts = 0;
        end else if (never) begin
            // One LAUNCH cycle plus TIMEOUT cycles in WAIT.
            e.q = '0; e.r = '0; e.err = ERR_TIMEOUT; e.lat = TO + 1; e.starts = 1;
        end else begin
            e.q = s.q; e.r = s.r; e.err = ovf ? ERR_OVF : ERR_OK; e.lat = -1; e.starts = 1;
        end
        e.hs = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a = W'($urandom);
        bus.req_b = W'($urandom);
    endtask

    // Divider model: done is a level held until the next start.
    initial begin
        scen_t s;
        bus.div_done = 1'b0; bus.div_overflow = 1'b0;
        bus.div_quotient = '0; bus.div_remainder = '0;
        forever begin
            @(negedge clk);
            if (!reset_a && bus.div_start) begin
                if (scen_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_start: div_start=1 with no request pending, expected 0");
                end else begin
                    s = scen_q.pop_front();
                    check("div_dividen", 64'(bus.div_dividen), 64'(s.a));
                    check("div_divisor", 64'(bus.div_divisor), 64'(s.b));
                    if (s.stale > 0) repeat (s.stale + 1) @(negedge clk);
                    bus.div_done = 1'b0;
                    bus.div_overflow = 1'b0;
                    if (!s.never) begin
                        repeat (s.lat) @(negedge clk);
                        bus.div_quotient  = s.q;
                        bus.div_remainder = s.r;
                        bus.div_overflow  = s.ovf;
                        bus.div_done      = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: checks response timing, stability and contents.
    initial begin
        exp_t         e;
        bit           pend;
        logic [W-1:0] pq, pr;
        logic [1:0]   pe;
        pend = 1'b0; pq = '0; pr = '0; pe = '0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_a) begin
                pend = 1'b0;
                bus.rsp_ready = 1'b0;
            end else begin
                if (bus.div_start) start_cnt++;
                if (pend) check("rsp_valid_hold", 64'(bus.rsp_valid), 64'd1);
                if (bus.rsp_valid && exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with empty scoreboard, expected 0");
                    bus.rsp_ready = 1'b1;
                    pend = 1'b0;
                end else if (bus.rsp_valid) begin
                    if (!pend) begin
                        if (exp_q[0].lat >= 0)
                            check("rsp_latency", 64'(cyc - exp_q[0].hs), 64'(exp_q[0].lat));
                    end else begin
                        check("rsp_stable", {bus.rsp_quot, bus.rsp_rem, bus.rsp_err}, {pq, pr, pe});
                    end
                    if (stall_cnt > 0) begin
                        bus.rsp_ready = 1'b0;
                        stall_cnt--;
                    end else begin
                        bus.rsp_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (bus.rsp_ready) begin
                        e = exp_q.pop_front();
                        check("rsp_quot", 64'(bus.rsp_quot), 64'(e.q));
                        check("rsp_rem", 64'(bus.rsp_rem), 64'(e.r));
                        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                        check("div_start_count", 64'(start_cnt), 64'(e.starts));
                        start_cnt = 0;
                        pend = 1'b0;
                    end else begin
                        pend = 1'b1;
                        pq = bus.rsp_quot; pr = bus.rsp_rem; pe = bus.rsp_err;
                    end
                end else begin
                    bus.rsp_ready = 1'b0;
                    pend = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    // Stimulus
    initial begin
        int guard;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_a = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.req_ready), 64'd1);

        // Reset while in WAIT straight after the start pulse.
        send(16'd100, 16'd7, 1'b0, 1'b1, 0, 0);
        guard = 0;
        while (!bus.div_start && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("start_before_reset", 64'(bus.div_start), 64'd1);
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        check_all_zero("midop_reset");
        exp_q.delete();
        scen_q.delete();
        start_cnt = 0;
        reset_a = 1'b0;
        @(negedge clk);
        check("ready_after_midop_reset", 64'(bus.req_ready), 64'd1);

        stall_cnt = 3;
        send(16'd100, 16'd7, 1'b0, 1'b0, 0, 18);
        send(16'd55, 16'd0, 1'b0, 1'b0, 0, 0);
        send(16'd10, 16'd3, 1'b0, 1'b0, 2, 3);
        send(16'd1234, 16'd17, 1'b0, 1'b1, 0, 0);
        send(16'd999, 16'd10, 1'b0, 1'b0, 0, 5);
        send(16'd40000, 16'd3, 1'b1, 1'b0, 0, 7);
        send(16'd0, 16'd0, 1'b0, 1'b0, 0, 0);
        send(16'hFFFF, 16'd1, 1'b0, 1'b0, 1, 1);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0
               : (($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300)) : W'($urandom));
            send(ra, rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 3), $urandom_range(1, 30));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Request/response front-end that sits directly upstream of the 16-bit sequential divider in the ALU. It accepts one dividend/divisor pair per valid/ready handshake and screens divide-by-zero without launching the divider. Otherwise it drives the divider's operand and `start` inputs, waits for `done` under a watchdog, and returns quotient, remainder and an error code over a valid/ready response channel.

## Interface
- `WIDTH`, 16: operand/result width; must match the divider.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the operation is aborted; must be at least 2.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_a`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request operands valid.
- `req_ready`  out  1  sequencer can accept a request.
- `req_a`  in  WIDTH  dividend.
- `req_b`  in  WIDTH  divisor.
- `rsp_valid`  out  1  response valid, held until accepted.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_quot`  out  WIDTH  quotient.
- `rsp_rem`  out  WIDTH  remainder.
- `rsp_err`  out  2  error code: 00 ok, 01 divide-by-zero, 10 divider overflow, 11 timeout.
- `div_dividen`  out  WIDTH  to divider `dividen`; registered copy of `req_a`.
- `div_divisor`  out  WIDTH  to divider `divisor`; registered copy of `req_b`.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_quotient`, `div_remainder`  in  WIDTH  from the divider.
- `div_done`, `div_overflow`  in  1  from the divider; `div_done` is treated as a level.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP. All outputs are registered or decoded from state only.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture `req_a`/`req_b` into the operand registers.
  - If `req_b`==0, go to RESP with `rsp_err`=01, `rsp_quot`=all ones, `rsp_rem`=`req_a`. The divider is not started.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - `div_start`=1 for exactly this cycle.
  - Clear the watchdog counter and the `armed` flag. Go to WAIT.
- WAIT:
  - The watchdog counter increments every cycle.
  - `armed` sets the first cycle `div_done`=0 is sampled. This rejects a `done` level still held from the previous operation.
  - When `armed` is set (registered) and `div_done`=1: capture `div_quotient`/`div_remainder`, set `rsp_err`=10 if `div_overflow` else 00, and go to RESP.
  - If the counter reaches `TIMEOUT`-1 without a qualifying done: set `rsp_quot`=0, `rsp_rem`=0, `rsp_err`=11, and go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - `rsp_valid`=1; `rsp_*` are held stable.
  - On `rsp_ready`, return to IDLE. The next request is accepted no earlier than the following cycle.
- `div_dividen`/`div_divisor` stay stable from capture until the next capture.
- `div_done`/`div_overflow` are ignored outside WAIT.

## Timing
- Reset value of every output is 0; state is IDLE. `req_ready` rises in the first cycle after reset deasserts.
- `reset_a` asserted mid-operation: on the next edge, go to IDLE, clear all outputs, and drop `div_start`. Any pending response is discarded.
- Divide-by-zero latency: handshake at edge N, `rsp_valid`=1 after edge N+1 (one cycle).
- Normal latency:
  - Handshake at edge N.
  - `div_start` is high between edges N+1 and N+2.
  - WAIT begins at N+2.
  - `rsp_valid` is high the cycle after the qualifying `div_done` is sampled.
- Throughput: at most one operation in flight. `req_ready`=0 in LAUNCH, WAIT and RESP.
- Watchdog counter width is $clog2(`TIMEOUT`); the counter never wraps.

## Structure
- Shared package `div_pkg`:
  - `WIDTH` default.
  - Error-code constants `ERR_OK`, `ERR_DIV0`, `ERR_OVF`, `ERR_TIMEOUT`.
  - FSM state encoding.
- One natural sub-module, `div_watchdog`: the counter plus `armed` flag, with clear/enable inputs and `expired`/`done_q` outputs.
- The rest is a single FSM module. The divider is instantiated alongside it by the ALU, not inside it.

## Test plan
- Reset while in WAIT with `div_start` just pulsed -> next cycle: IDLE, all outputs 0, `req_ready`=1 the cycle after.
- Request 100/7, divider model answers done after 18 cycles with 14/2 -> one `div_start` pulse; response quot=14, rem=2, err=00; `rsp_valid` held through 3 cycles of `rsp_ready`=0.
- Request 55/0 -> no `div_start`; `rsp_valid` one cycle after handshake; quot=0xFFFF, rem=55, err=01.
- Divider model holds `div_done`=1 from the previous op into the new WAIT for 2 cycles, then drops it, then raises it with 3/1 -> the stale done is ignored; response 3/1, err=00.
- Divider model never raises done, `TIMEOUT`=64 -> response at WAIT cycle 63 with quot=0, rem=0, err=11; next request is accepted normally.
- Divider model raises `div_overflow` with done -> err=10, divider results passed through.
